// File: rtl/ascii_7seg_pkg.sv
// Shared definitions for the ASCII 7-segment terminal: glyph codes, control
// characters, the per-digit buffer entry and the ASCII-to-segment decoder.
package ascii_7seg_pkg;

  localparam int unsigned SEG_W = 7;

  // Internal patterns are active-high, bit order abcdefg (bit 6 = a).
  localparam logic [SEG_W-1:0] GLYPH_BLANK = 7'b0000000;
  localparam logic [SEG_W-1:0] GLYPH_ERR   = 7'b1001001;
  localparam logic [SEG_W-1:0] GLYPH_MINUS = 7'b0000001;

  localparam logic [7:0] CHAR_DOT = 8'h2E;
  localparam logic [7:0] CHAR_BS  = 8'h08;
  localparam logic [7:0] CHAR_CR  = 8'h0D;

  typedef struct packed {
    logic [SEG_W-1:0] pat;
    logic             dp;
  } digit_t;

  localparam int unsigned DIGIT_W = $bits(digit_t);
  localparam digit_t DIGIT_BLANK = '{pat: GLYPH_BLANK, dp: 1'b0};

  typedef enum logic [1:0] {
    CLS_GLYPH,
    CLS_DOT,
    CLS_BS,
    CLS_CR
  } char_cls_e;

  function automatic char_cls_e char_class(input logic [7:0] c);
    char_cls_e cls;
    case (c)
      CHAR_DOT: cls = CLS_DOT;
      CHAR_BS:  cls = CLS_BS;
      CHAR_CR:  cls = CLS_CR;
      default:  cls = CLS_GLYPH;
    endcase
    return cls;
  endfunction

  function automatic logic [SEG_W-1:0] ascii_to_glyph(input logic [7:0] c);
    logic [7:0]       u;
    logic [SEG_W-1:0] g;
    // Fold lower-case onto upper-case so one letter table serves both.
    u = ((c >= 8'h61) && (c <= 8'h7A)) ? (c - 8'h20) : c;
    case (u)
      8'h30: g = 7'b1111110;
      8'h31: g = 7'b0110000;
      8'h32: g = 7'b1101101;
      8'h33: g = 7'b1111001;
      8'h34: g = 7'b0110011;
      8'h35: g = 7'b1011011;
      8'h36: g = 7'b1011111;
      8'h37: g = 7'b1110000;
      8'h38: g = 7'b1111111;
      8'h39: g = 7'b1111011;
      8'h41: g = 7'b1110111;
      8'h42: g = 7'b0011111;
      8'h43: g = 7'b1001110;
      8'h44: g = 7'b0111101;
      8'h45: g = 7'b1001111;
      8'h46: g = 7'b1000111;
      8'h47: g = 7'b1011110;
      8'h48: g = 7'b0110111;
      8'h49: g = 7'b0000110;
      8'h4A: g = 7'b0111100;
      8'h4B: g = 7'b1010111;
      8'h4C: g = 7'b0001110;
      8'h4D: g = 7'b1010100;
      8'h4E: g = 7'b0010101;
      8'h4F: g = 7'b0011101;
      8'h50: g = 7'b1100111;
      8'h51: g = 7'b1110011;
      8'h52: g = 7'b0000101;
      8'h53: g = 7'b1011011;
      8'h54: g = 7'b0001111;
      8'h55: g = 7'b0111110;
      8'h56: g = 7'b0011100;
      8'h57: g = 7'b0101010;
      8'h58: g = 7'b0110110;
      8'h59: g = 7'b0111011;
      8'h5A: g = 7'b1101101;
      8'h2D: g = GLYPH_MINUS;
      8'h20: g = GLYPH_BLANK;
      default: g = GLYPH_ERR;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg_digit_mux.sv
// Digit scanner: slot counter, digit index and the registered, polarity-adjusted
// segment/anode outputs. The first cycle of each slot is a blank anti-ghost gap.
module seg_digit_mux
  import ascii_7seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned SCAN_DIV       = 1024,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  digit_t [NUM_DIGITS-1:0]     digits_i,
  output logic   [SEG_W-1:0]          seg_o,
  output logic                        dp_o,
  output logic   [NUM_DIGITS-1:0]     an_o
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  localparam logic [SEG_W-1:0]      SEG_XOR = {SEG_W{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_XOR  = {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  digit_t                sel;

  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    sel  = digits_i[idx_q];
    an_d = '0;
    seg_d = GLYPH_BLANK;
    dp_d  = 1'b0;
    if (cnt_q != '0) begin
      an_d[idx_q] = 1'b1;
      seg_d       = sel.pat;
      dp_d        = sel.dp;
    end
  end

  // Output flops hold the physical pin level, so reset drives them inactive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      seg_q <= SEG_XOR;
      dp_q  <= SEG_ACTIVE_LOW;
      an_q  <= AN_XOR;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d ^ SEG_XOR;
      dp_q  <= dp_d ^ SEG_ACTIVE_LOW;
      an_q  <= an_d ^ AN_XOR;
    end
  end

  assign seg_o = seg_q;
  assign dp_o  = dp_q;
  assign an_o  = an_q;

endmodule

// File: rtl/ascii_7seg_scanner.sv
// ASCII terminal front end: valid/ready handshake, decode at accept time and a
// right-justified, left-scrolling digit buffer feeding the scan multiplexer.
module ascii_7seg_scanner
  import ascii_7seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned SCAN_DIV       = 1024,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  char_valid,
  output logic                  char_ready,
  input  logic [7:0]            char_data,
  input  logic                  clear,
  output logic [SEG_W-1:0]      seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int unsigned BUF_W = NUM_DIGITS * DIGIT_W;

  digit_t [NUM_DIGITS-1:0] buf_q, buf_d;
  logic                    accept;
  char_cls_e               cls;
  logic [SEG_W-1:0]        glyph;
  logic                    do_shift;
  digit_t                  shift_val;
  logic [BUF_W+DIGIT_W-1:0] ext_left, ext_right;

  assign char_ready = ~clear;
  assign accept     = char_valid & char_ready;

  // Shifts are done on a widened flat vector so NUM_DIGITS=1 needs no special case.
  assign ext_left  = {buf_q, shift_val};
  assign ext_right = {DIGIT_BLANK, buf_q};

  always_comb begin
    glyph     = ascii_to_glyph(char_data);
    cls       = char_class(char_data);
    do_shift  = 1'b0;
    shift_val = '{pat: glyph, dp: 1'b0};
    buf_d     = buf_q;

    if (clear || (accept && (cls == CLS_CR))) begin
      buf_d = '0;
    end else if (accept) begin
      case (cls)
        CLS_BS: buf_d = ext_right[BUF_W+DIGIT_W-1:DIGIT_W];
        CLS_DOT: begin
          if (!buf_q[0].dp) begin
            buf_d[0].dp = 1'b1;
          end else begin
            shift_val = '{pat: GLYPH_BLANK, dp: 1'b1};
            do_shift  = 1'b1;
          end
        end
        default: do_shift = 1'b1;
      endcase
      if (do_shift) begin
        buf_d = ext_left[BUF_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q <= '0;
    end else begin
      buf_q <= buf_d;
    end
  end

  seg_digit_mux #(
    .NUM_DIGITS    (NUM_DIGITS),
    .SCAN_DIV      (SCAN_DIV),
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW),
    .AN_ACTIVE_LOW (AN_ACTIVE_LOW)
  ) u_mux (
    .clk     (clk),
    .rst     (rst),
    .digits_i(buf_q),
    .seg_o   (seg),
    .dp_o    (dp),
    .an_o    (an)
  );

endmodule
